led_level_monitor: RTL and testbench

//  Reader for the thermometer-coded LED bus driven by the step state machine.

---
 rtl/led_mon_pkg.sv | 21 ++
 rtl/led_level_monitor_if.sv | 26 ++
 rtl/led_sync_stable.sv | 60 ++++++
 rtl/led_level_monitor.sv | 108 ++++++++++
 tb/tb_led_level_monitor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/led_mon_pkg.sv
// rtl/led_mon_pkg.sv - shared types and thermometer-code helpers for the LED level monitor
// Purpose: FSM state type plus legality check and decode of thermometer codes.
// Ports: none (package). Helpers take codes zero-extended to 32 bits.
package led_mon_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} led_mon_state_t;

  // A thermometer code is 2**k-1: adding one clears every set bit.
  function automatic logic is_thermo(input logic [31:0] code);
    return ((code + 32'd1) & code) == 32'd0;
  endfunction

  // Number of lit segments; only meaningful for legal codes.
  function automatic int unsigned thermo2bin(input logic [31:0] code);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(code[i]);
    return n;
  endfunction

endpackage

// File: rtl/led_level_monitor_if.sv
// rtl/led_level_monitor_if.sv - LED bus and status bundle for the LED level monitor
// Purpose: groups the observed LED bus, count clear and all decoded status outputs.
// Modports: master drives led_in/clr_count and reads status; slave is the monitor.
interface led_level_monitor_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]           led_in;
  logic                       clr_count;
  logic [$clog2(WIDTH+1)-1:0] level;
  logic                       level_valid;
  logic                       step_up;
  logic                       step_down;
  logic                       illegal;
  logic [CNT_W-1:0]           step_count;

  modport master (
    output led_in, clr_count,
    input  level, level_valid, step_up, step_down, illegal, step_count
  );

  modport slave (
    input  led_in, clr_count,
    output level, level_valid, step_up, step_down, illegal, step_count
  );
endinterface

// File: rtl/led_sync_stable.sv
// rtl/led_sync_stable.sv - two-flop synchroniser plus stability filter for the LED bus
// Purpose: brings led_i into the clk domain and accepts a code once it has been
//          sampled identically STABLE_CYCLES times in a row.
// Ports: clk, rst (async active-high); led_i async LED bus;
//        code_o synchronised code; accept_o 1-cycle strobe when code_o is accepted.
module led_sync_stable #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_i,
  output logic [WIDTH-1:0] code_o,
  output logic             accept_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] meta_q, sync_q, cand_q, cand_d;
  logic [1:0]       fill_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      fill_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= led_i;
      sync_q <= meta_q;
      fill_q <= {fill_q[0], 1'b1};
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // fill_q masks the reset value of the chain so the first real sample
  // starts a fresh candidate; a zero count means no candidate yet.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    if (fill_q[1]) begin
      if (cnt_q == '0 || sync_q != cand_q) begin
        cand_d = sync_q;
        cnt_d  = CW'(1);
      end else if (cnt_q != STABLE) begin
        cnt_d = cnt_q + CW'(1);
      end
      // Fire only on the transition into the saturated count.
      accept_o = (cnt_d == STABLE) && (cnt_q != STABLE || sync_q != cand_q);
    end
  end

  assign code_o = sync_q;

endmodule

// File: rtl/led_level_monitor.sv
// rtl/led_level_monitor.sv - decodes the thermometer LED bus into a level with step events
// Purpose: filters the LED bus, tracks the accepted level through IDLE/TRACK/FAULT,
//          pulses step_up/step_down on changes and counts them.
// Ports: clk, rst (async active-high); bus (slave modport): led_in, clr_count in;
//        level, level_valid, step_up, step_down, illegal, step_count out.
// Config: LED_MON_SAT_COUNT_EN makes step_count saturate instead of wrap.
module led_level_monitor
  import led_mon_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  led_level_monitor_if.slave  bus
);

  localparam int LVL_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] code;
  logic             accept;
  logic             legal;
  logic [LVL_W-1:0] new_level;

  led_mon_state_t   state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d, down_q, down_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_evt;

  led_sync_stable #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync_stable (
    .clk      (clk),
    .rst      (rst),
    .led_i    (bus.led_in),
    .code_o   (code),
    .accept_o (accept)
  );

  assign legal     = is_thermo(32'(code));
  assign new_level = LVL_W'(thermo2bin(32'(code)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      down_q  <= down_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    valid_d  = valid_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    step_evt = 1'b0;
    if (accept) begin
      if (!legal) begin
        state_d = FAULT;
      end else begin
        state_d = TRACK;
        valid_d = 1'b1;
        level_d = new_level;
        // No level has been reported yet, so the first legal code is not a step.
        if (valid_q && new_level != level_q) begin
          step_evt = 1'b1;
          up_d     = new_level > level_q;
          down_d   = new_level < level_q;
        end
      end
    end

    cnt_d = cnt_q;
    if (bus.clr_count) begin
      cnt_d = '0;
`ifdef LED_MON_SAT_COUNT_EN
    end else if (step_evt && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
`else
    end else if (step_evt) begin
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  assign bus.level       = level_q;
  assign bus.level_valid = valid_q;
  assign bus.step_up     = up_q;
  assign bus.step_down   = down_q;
  assign bus.illegal     = (state_q == FAULT);
  assign bus.step_count  = cnt_q;

endmodule

// File: tb/tb_led_level_monitor.sv
// tb/tb_led_level_monitor.sv - directed self-checking bench for led_level_monitor
module tb_led_level_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic evt_seen;

  led_level_monitor_if #(.WIDTH(3), .CNT_W(8)) bus  ();
  led_level_monitor_if #(.WIDTH(3), .CNT_W(2)) bus2 ();

  led_level_monitor #(.WIDTH(3), .STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  led_level_monitor #(.WIDTH(3), .STABLE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_led(input logic [2:0] v);
    bus.led_in  = v;
    bus2.led_in = v;
  endtask

  task automatic set_clr(input logic v);
    bus.clr_count  = v;
    bus2.clr_count = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (bus.step_up || bus.step_down) evt_seen = 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    evt_seen = 1'b0;
    rst      = 1'b1;
    set_led(3'b000);
    set_clr(1'b0);

    // 1: reset state, then first acceptance on edge 6 without a step pulse
    tick(3);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_valid", 32'(bus.level_valid), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_count", 32'(bus.step_count), 0);
    rst = 1'b0;
    tick(5);
    chk("init_valid_e5", 32'(bus.level_valid), 0);
    tick(1);
    chk("init_valid_e6", 32'(bus.level_valid), 1);
    chk("init_level_e6", 32'(bus.level), 0);
    chk("init_noup_e6", 32'(bus.step_up), 0);
    tick(4);

    // 2: climb 000 -> 001 -> 011 -> 111
    for (int k = 1; k <= 3; k++) begin
      logic [2:0] code;
      code = 3'((1 << k) - 1);
      set_led(code);
      tick(5);
      chk("climb_level_e5", 32'(bus.level), 32'(k - 1));
      chk("climb_up_e5", 32'(bus.step_up), 0);
      tick(1);
      chk("climb_up_e6", 32'(bus.step_up), 1);
      chk("climb_down_e6", 32'(bus.step_down), 0);
      chk("climb_level_e6", 32'(bus.level), 32'(k));
      chk("climb_count_e6", 32'(bus.step_count), 32'(k));
      tick(1);
      chk("climb_up_e7", 32'(bus.step_up), 0);
      tick(3);
    end

    // 3: two-sample glitch to 001 is filtered out
    evt_seen = 1'b0;
    set_led(3'b001);
    tick_watch(2);
    set_led(3'b111);
    tick_watch(10);
    chk("glitch_event", 32'(evt_seen), 0);
    chk("glitch_level", 32'(bus.level), 3);
    chk("glitch_count", 32'(bus.step_count), 3);

    // 4: illegal code 101 holds level, then 011 recovers with one step_down
    set_led(3'b101);
    tick(5);
    chk("ill_e5", 32'(bus.illegal), 0);
    tick(1);
    chk("ill_e6", 32'(bus.illegal), 1);
    chk("ill_level", 32'(bus.level), 3);
    chk("ill_valid", 32'(bus.level_valid), 1);
    chk("ill_nostep", 32'(bus.step_up | bus.step_down), 0);
    tick(4);
    set_led(3'b011);
    tick(5);
    chk("rec_ill_e5", 32'(bus.illegal), 1);
    tick(1);
    chk("rec_ill_e6", 32'(bus.illegal), 0);
    chk("rec_down", 32'(bus.step_down), 1);
    chk("rec_up", 32'(bus.step_up), 0);
    chk("rec_level", 32'(bus.level), 2);
    chk("rec_count", 32'(bus.step_count), 4);
    tick(4);

    // 5: clear coinciding with an acceptance, then wrap/saturate on a 2-bit counter
    set_led(3'b111);
    tick(5);
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    chk("clr_acc_count", 32'(bus.step_count), 0);
    chk("clr_acc_up", 32'(bus.step_up), 1);
    chk("clr_acc_level", 32'(bus.level), 3);
    chk("clr_acc_count2", 32'(bus2.step_count), 0);
    tick(4);
    for (int i = 0; i < 5; i++) begin
      set_led((i % 2 == 0) ? 3'b011 : 3'b111);
      tick(7);
    end
    chk("five_count", 32'(bus.step_count), 5);
    chk("five_level", 32'(bus.level), 2);
`ifdef LED_MON_SAT_COUNT_EN
    chk("five_count_w2", 32'(bus2.step_count), 3);
`else
    chk("five_count_w2", 32'(bus2.step_count), 1);
`endif
    set_clr(1'b1);
    tick(1);
    set_clr(1'b0);
    chk("clr_only", 32'(bus.step_count), 0);

    // 6: asynchronous reset mid-filter discards the candidate
    set_led(3'b111);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(bus.level), 0);
    chk("arst_valid", 32'(bus.level_valid), 0);
    chk("arst_illegal", 32'(bus.illegal), 0);
    tick(1);
    rst = 1'b0;
    tick(5);
    chk("post_valid_e5", 32'(bus.level_valid), 0);
    tick(1);
    chk("post_valid_e6", 32'(bus.level_valid), 1);
    chk("post_level_e6", 32'(bus.level), 3);
    chk("post_noup_e6", 32'(bus.step_up), 0);
    chk("post_count_e6", 32'(bus.step_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
